// File: rtl/alu_exec_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_unit_pkg
// Shared definitions for the ALU decoder and the execute-stage ALU.
//   alu_op_t     : 3-bit ALU_Control code
//   ALU_*        : operation encodings used by both the decoder and this unit
//   alu_flags_t  : condition flags held in the output register
// -----------------------------------------------------------------------------
package alu_exec_unit_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;
    localparam alu_op_t ALU_OR  = 3'b011;
    localparam alu_op_t ALU_ILL = 3'b100;
    localparam alu_op_t ALU_SLT = 3'b101;
    localparam alu_op_t ALU_BEQ = 3'b110;
    localparam alu_op_t ALU_XOR = 3'b111;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_exec_unit_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath.
//   op       in  : ALU_Control code
//   a, b     in  : operands
//   result   out : WIDTH-bit result (modulo 2^WIDTH)
//   carry    out : ADD carry-out, SUB/BEQ no-borrow (a >= b unsigned), else 0
//   overflow out : signed overflow for ADD/SUB/BEQ, else 0
//   illegal  out : op is the reserved code 100
// -----------------------------------------------------------------------------
module alu_core
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_t            op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               overflow,
    output logic               illegal
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             add_ovf;

    // One shared adder: subtraction is a + ~b + 1, so carry-out doubles as
    // the unsigned no-borrow indication.
    assign is_sub  = (op == ALU_SUB) || (op == ALU_BEQ);
    assign b_eff   = is_sub ? ~b : b;
    assign sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_BEQ: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = add_ovf;
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_ILL: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Two-stage execute ALU with valid/ready handshake on both sides.
//   S1 registers {op, A, B}; S2 registers {Result, flags}.
//   clk, rst (sync, active-low)
//   in_valid/in_ready, ALU_Control, A, B        : upstream operation
//   out_valid/out_ready, Result, Zero, Negative,
//   Carry, Overflow, illegal_op                 : registered result
// One operation per cycle with full backpressure; in_ready depends only on
// rst and the stage state, never on in_valid.
// -----------------------------------------------------------------------------
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALU_Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             illegal_op
);

    logic             s1_valid_q, s1_valid_d;
    alu_op_t          s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    alu_flags_t       flags_q,     flags_d;

    logic             s2_load;
    logic             accept;
    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_overflow;
    logic             core_illegal;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op       (s1_op_q),
        .a        (s1_a_q),
        .b        (s1_b_q),
        .result   (core_result),
        .carry    (core_carry),
        .overflow (core_overflow),
        .illegal  (core_illegal)
    );

    always_comb begin
        // S2 takes S1 whenever it is empty or being drained this cycle.
        s2_load  = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = rst && (!s1_valid_q || s2_load);
        accept   = in_valid && in_ready;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = alu_op_t'(ALU_Control);
            s1_a_d     = A;
            s1_b_d     = B;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (s2_load) begin
            out_valid_d      = 1'b1;
            result_d         = core_result;
            // Zero/Negative come from the final result before the register.
            flags_d.zero     = (core_result == '0);
            flags_d.negative = core_result[WIDTH-1];
            flags_d.carry    = core_carry;
            flags_d.overflow = core_overflow;
            flags_d.illegal  = core_illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    // NOTE: the S1 payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_op_q <= s1_op_d;
        s1_a_q  <= s1_a_d;
        s1_b_q  <= s1_b_d;
    end

    assign out_valid  = out_valid_q;
    assign Result     = result_q;
    assign Zero       = flags_q.zero;
    assign Negative   = flags_q.negative;
    assign Carry      = flags_q.carry;
    assign Overflow   = flags_q.overflow;
    assign illegal_op = flags_q.illegal;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Pipelined execute-stage ALU: the consumer end of the `ALU_Control` interface driven by the ALU decoder. It takes a 3-bit `ALU_Control` code and two operands under a valid/ready handshake, registers them, computes the result and condition flags, and holds them in an output register until the downstream stage accepts. It sits between decode/register-read and memory/writeback in the multi-cycle and pipelined core variants. Throughput is one operation per cycle with full backpressure.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept this cycle
- ALU_Control  input  3  operation code, decoder encoding
- A  input  WIDTH  operand A (rs1)
- B  input  WIDTH  operand B (rs2 or immediate)
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  downstream accepts the result this cycle
- Result  output  WIDTH  registered result
- Zero  output  1  Result == 0
- Negative  output  1  Result[WIDTH-1]
- Carry  output  1  ADD carry-out; SUB/BEQ no-borrow (A ≥ B unsigned); else 0
- Overflow  output  1  signed overflow for ADD/SUB/BEQ; else 0
- illegal_op  output  1  registered op was code 100

## Operation
- Codes: 000 ADD A+B; 001 SUB A−B; 010 AND; 011 OR; 101 SLT → {0…, signed(A)<signed(B)}; 110 BEQ → A−B, with Zero giving equality; 111 XOR; 100 illegal → Result 0, Zero 1, illegal_op 1, Carry/Overflow 0.
- Arithmetic is modulo 2^WIDTH. Carry is bit WIDTH of the (WIDTH+1)-bit sum A + (~B or B) + cin. Overflow = (A[msb] == B'[msb]) && (Result[msb] != A[msb]), where B' is the effective addend.
- Two register stages, each with a valid bit:
  - S1 holds {op, A, B}.
  - S2 holds {Result, flags}.
- Advance rules:
  - s2_load = s1_valid && (!out_valid || out_ready)
  - in_ready = rst && (!s1_valid || s2_load)
  - Input transfer when in_valid && in_ready.
- Output handshake: while out_valid && !out_ready, Result, the flags and out_valid stay stable. Once offered, out_valid never drops until the result is accepted.
- Simultaneous events: accept into S1 and move S1→S2 in the same cycle. Downstream take and S2 reload in the same cycle. No bubble is inserted in either case.
- Pipeline full (S1 and S2 valid, out_ready=0): in_ready=0 and all registers hold.
- Reset (rst=0 at a clock edge), including mid-operation:
  - s1_valid and out_valid cleared.
  - Result, Zero, Negative, Carry, Overflow, illegal_op ← 0.
  - In-flight operations are discarded.
  - in_ready=0 while rst is low.

## Timing
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+1, provided S2 is free.
- Sustained 1 op/cycle when out_ready stays high.
- All outputs are registered except in_ready, which is combinational from out_valid, out_ready, s1_valid and rst. There is no combinational path from in_valid to in_ready.
- Zero and Negative are computed in S2 from the final result, so no flag logic sits after the register.

## Structure
- Shared package: `ALU_ADD=3'b000`, `ALU_SUB=3'b001`, `ALU_AND=3'b010`, `ALU_OR=3'b011`, `ALU_ILL=3'b100`, `ALU_SLT=3'b101`, `ALU_BEQ=3'b110`, `ALU_XOR=3'b111`. The decoder and this unit both use these constants.
- One combinational sub-module, `alu_core`, takes (op, A, B) and returns (Result, Carry, Overflow, illegal). The top level contains only the two stage registers and the handshake logic.

## Test plan
- Reset, then ADD A=5, B=7 with out_ready=1 → after two edges: out_valid=1, Result=12, Zero=0, Carry=0.
- SUB A=3, B=5 → Result=0xFFFFFFFE, Negative=1, Carry=0. BEQ A=B=0x1234 → Zero=1, Carry=1. SLT A=0xFFFFFFFF, B=1 → Result=1.
- ADD A=0x7FFFFFFF, B=1 → Overflow=1, Negative=1. ADD A=0xFFFFFFFF, B=1 → Result=0, Carry=1, Zero=1. Op 100 → illegal_op=1, Result=0.
- Stream 4 back-to-back ops with out_ready held at 0 → in_ready drops after 2 accepts and out_valid/Result stay stable. Release out_ready → all 4 results emerge in order, one per cycle, with none lost or duplicated.
- Randomized in_valid/out_ready over 1000 ops, checked against a reference model → result order and values match and there are no handshake violations.
- Assert rst=0 with both stages full → next cycle: out_valid=0, all outputs 0, in_ready=0. Release rst → in_ready=1 and new ops flow normally.
